mul_share_ctrl: RTL and testbench

Round-robin arbiter and sequencer that shares one instance of the team's combinational 16x16 unsigned array multiplier (`multiplier`) among NREQ requesters. It registers the winner's operands and holds them stable for a programmable settle window that covers the multiplier's long ripple path. It then registers the 32-bit product and returns it with the requester ID over a valid/ready response port. It sits between multiple datapath clients and the single multiplier, so no client sees the unregistered array output.

---
 rtl/mul_share_ctrl.sv | 119 +++++++++++
 tb/tb_mul_share_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_ctrl.sv
// Round-robin front end that shares one combinational 16x16 array multiplier
// among NREQ requesters, holding operands for SETTLE cycles before sampling.

module multiplier (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [32:0] p_o
);
  always_comb begin
    p_o = '0;
    for (int j = 0; j < 16; j++)
      if (b_i[j]) p_o = p_o + ({17'b0, a_i} << j);
  end
endmodule

module mul_share_ctrl #(
  parameter int NREQ   = 4,
  parameter int SETTLE = 4,
  parameter int IDW    = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*16-1:0]   req_a,
  input  logic [NREQ*16-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_p,
  output logic [IDW-1:0]       rsp_id,
  output logic                 busy
);
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t          state_q;
  logic [IDW-1:0]  ptr_q, id_q, rsp_id_q;
  logic [CW-1:0]   cnt_q;
  logic [15:0]     op_a_q, op_b_q;
  logic [31:0]     rsp_p_q;
  logic            rsp_valid_q, busy_q;
  logic [32:0]     prod_unused_msb;

  logic [IDW-1:0]  gnt_idx;
  logic            gnt_vld;
  int              idx;

  multiplier u_mul (
    .a_i (op_a_q),
    .b_i (op_b_q),
    .p_o (prod_unused_msb)
  );

  // Walk downward so the lowest offset from ptr is the last (winning) write.
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDW'(idx);
      end
    end
  end

  assign req_ready = (state_q == IDLE && !rst && gnt_vld) ? (NREQ'(1) << gnt_idx) : '0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_p     = rsp_p_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_p_q     <= '0;
      rsp_id_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (gnt_vld) begin
          op_a_q  <= req_a[int'(gnt_idx)*16 +: 16];
          op_b_q  <= req_b[int'(gnt_idx)*16 +: 16];
          id_q    <= gnt_idx;
          ptr_q   <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
          cnt_q   <= CW'(SETTLE - 1);
          state_q <= WAIT;
          busy_q  <= 1'b1;
        end
        WAIT: if (cnt_q == '0) begin
          rsp_p_q     <= prod_unused_msb[31:0];
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= DONE;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
        DONE: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
          busy_q      <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mul_share_ctrl.sv
// Scoreboard bench for mul_share_ctrl: expected products are queued at accept
// and compared when the response appears.

module tb_mul_share_ctrl;
  localparam int NREQ = 4, SETTLE = 4, IDW = 2;

  logic                clk = 1'b0, rst = 1'b1;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ*16-1:0]  req_a = '0, req_b = '0;
  logic [NREQ-1:0]     req_ready;
  logic                rsp_valid, busy;
  logic                rsp_ready = 1'b1;
  logic [31:0]         rsp_p;
  logic [IDW-1:0]      rsp_id;

  mul_share_ctrl #(.NREQ(NREQ), .SETTLE(SETTLE), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_p(rsp_p), .rsp_id(rsp_id), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {int id; logic [31:0] p;} exp_t;
  exp_t sb[$];
  exp_t e;
  int n_pass = 0, n_total = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_grant(output int id, output int t);
    bit got;
    id = -1; t = -1; got = 0;
    #1;
    for (int k = 0; k < 40 && !got; k++) begin
      if (|req_ready) begin
        for (int j = 0; j < NREQ; j++) if (req_ready[j]) id = j;
        t = cyc; got = 1;
      end else step;
    end
  endtask

  // Pushes the expectation and steps across the accept edge.
  task automatic accept(input int id, input logic [31:0] p);
    exp_t x;
    if (id >= 0) begin
      x.id = id; x.p = p;
      sb.push_back(x);
    end
    step;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 40) begin step; lat++; end
    if (!rsp_valid) lat = -1;
  endtask

  task automatic pop_exp;
    if (sb.size() > 0) e = sb.pop_front();
    else begin e.id = -1; e.p = 32'hxxxx_xxxx; end
  endtask

  function automatic logic [31:0] prod(input int i);
    return 32'(req_a[16*i +: 16]) * 32'(req_b[16*i +: 16]);
  endfunction

  task automatic test_reset;
    req_valid = '1;
    step;
    n_total++; if (req_ready !== '0) $display("FAIL reset_ready: got %b expected 0", req_ready); else n_pass++;
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    n_total++; if (rsp_p !== 32'h0) $display("FAIL reset_rsp_p: got %h expected 0", rsp_p); else n_pass++;
    n_total++; if (rsp_id !== '0) $display("FAIL reset_rsp_id: got %0d expected 0", rsp_id); else n_pass++;
    req_valid = '0;
    rst = 1'b0;
    step;
  endtask

  task automatic test_single;
    int id, t, lat;
    set_req(2, 16'd3, 16'd5);
    wait_grant(id, t);
    n_total++; if (req_ready !== 4'b0100) $display("FAIL single_ready: got %b expected 0100", req_ready); else n_pass++;
    accept(id, 32'd15);
    req_valid = '0;
    n_total++; if (busy !== 1'b1) $display("FAIL single_busy: got %b expected 1", busy); else n_pass++;
    wait_rsp(lat);
    n_total++; if (lat != SETTLE + 1) $display("FAIL single_latency: got %0d expected %0d", lat, SETTLE + 1); else n_pass++;
    pop_exp;
    n_total++; if (rsp_p !== e.p) $display("FAIL single_p: got %h expected %h", rsp_p, e.p); else n_pass++;
    n_total++; if (int'(rsp_id) != e.id) $display("FAIL single_id: got %0d expected %0d", rsp_id, e.id); else n_pass++;
    step;
    n_total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL single_idle: got valid=%b busy=%b expected 0 0", rsp_valid, busy); else n_pass++;
  endtask

  task automatic test_extremes;
    logic [15:0] ta[3] = '{16'hFFFF, 16'h1234, 16'h0001};
    logic [15:0] tb[3] = '{16'hFFFF, 16'h0000, 16'hABCD};
    logic [31:0] tp[3] = '{32'hFFFE0001, 32'h0, 32'h0000ABCD};
    int id, t, lat;
    for (int n = 0; n < 3; n++) begin
      set_req(1, ta[n], tb[n]);
      wait_grant(id, t);
      n_total++; if (id != 1) $display("FAIL extreme_grant%0d: got %0d expected 1", n, id); else n_pass++;
      accept(id, tp[n]);
      req_valid = '0;
      wait_rsp(lat);
      pop_exp;
      n_total++; if (rsp_p !== e.p) $display("FAIL extreme_p%0d: got %h expected %h", n, rsp_p, e.p); else n_pass++;
      n_total++; if (int'(rsp_id) != e.id) $display("FAIL extreme_id%0d: got %0d expected %0d", n, rsp_id, e.id); else n_pass++;
      step;
    end
  endtask

  task automatic test_contention;
    int id, t, tprev, lat;
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 16'((i + 1) * 16'h0101), 16'((i + 3) * 16'h0011));
    step;
    rst = 1'b0;
    tprev = 0;
    for (int g = 0; g < 5; g++) begin
      wait_grant(id, t);
      n_total++; if (id != g % NREQ) $display("FAIL contention_order%0d: got %0d expected %0d", g, id, g % NREQ); else n_pass++;
      if (g > 0) begin
        n_total++; if (t - tprev != SETTLE + 2) $display("FAIL contention_interval%0d: got %0d expected %0d", g, t - tprev, SETTLE + 2); else n_pass++;
      end
      tprev = t;
      accept(id, (id >= 0) ? prod(id) : 32'h0);
      wait_rsp(lat);
      pop_exp;
      n_total++; if (rsp_p !== e.p || int'(rsp_id) != e.id)
        $display("FAIL contention_rsp%0d: got id=%0d p=%h expected id=%0d p=%h", g, rsp_id, rsp_p, e.id, e.p);
      else n_pass++;
      step;
    end
    req_valid = '0;
    step;
  endtask

  task automatic test_backpressure;
    int id, t, lat;
    logic [31:0] sp;
    logic [IDW-1:0] sid;
    rsp_ready = 1'b0;
    set_req(2, 16'h00C3, 16'h0101);
    wait_grant(id, t);
    accept(id, (id >= 0) ? prod(id) : 32'h0);
    req_valid = '0;
    wait_rsp(lat);
    pop_exp;
    n_total++; if (rsp_p !== e.p || int'(rsp_id) != e.id)
      $display("FAIL stall_rsp: got id=%0d p=%h expected id=%0d p=%h", rsp_id, rsp_p, e.id, e.p);
    else n_pass++;
    sp = rsp_p; sid = rsp_id;
    req_valid[0] = 1'b1;
    for (int c = 0; c < 7; c++) begin
      step;
      n_total++; if (rsp_valid !== 1'b1 || rsp_p !== sp || rsp_id !== sid || req_ready !== '0)
        $display("FAIL stall_hold%0d: got v=%b p=%h id=%0d rdy=%b expected v=1 p=%h id=%0d rdy=0", c, rsp_valid, rsp_p, rsp_id, req_ready, sp, sid);
      else n_pass++;
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    step;
    n_total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL stall_release: got valid=%b busy=%b expected 0 0", rsp_valid, busy); else n_pass++;
  endtask

  task automatic test_reset_mid_wait;
    int id, t, lat;
    bit seen;
    set_req(1, 16'h0055, 16'h0077);
    wait_grant(id, t);
    accept(id, (id >= 0) ? prod(id) : 32'h0);
    req_valid = '0;
    step;
    req_valid = 4'b1001;
    rst = 1'b1;
    #1;
    n_total++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== '0)
      $display("FAIL midrst_ctrl: got busy=%b v=%b rdy=%b expected 0 0 0", busy, rsp_valid, req_ready);
    else n_pass++;
    n_total++; if (rsp_p !== 32'h0 || rsp_id !== '0) $display("FAIL midrst_data: got p=%h id=%0d expected 0 0", rsp_p, rsp_id); else n_pass++;
    sb.delete();
    step;
    req_valid = '0;
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 10; c++) begin step; if (rsp_valid) seen = 1; end
    n_total++; if (seen) $display("FAIL midrst_no_rsp: got rsp_valid=1 expected none"); else n_pass++;
    set_req(0, 16'h0101, 16'h0202);
    set_req(3, 16'h0303, 16'h0404);
    wait_grant(id, t);
    n_total++; if (id != 0) $display("FAIL midrst_ptr: got %0d expected 0", id); else n_pass++;
    accept(id, (id >= 0) ? prod(id) : 32'h0);
    req_valid = '0;
    wait_rsp(lat);
    pop_exp;
    n_total++; if (rsp_p !== e.p || int'(rsp_id) != e.id)
      $display("FAIL midrst_rsp: got id=%0d p=%h expected id=%0d p=%h", rsp_id, rsp_p, e.id, e.p);
    else n_pass++;
    step;
  endtask

  task automatic test_fairness;
    int order[4] = '{0, 3, 0, 3};
    int id, t, lat;
    set_req(0, 16'h0010, 16'h0020);
    for (int g = 0; g < 4; g++) begin
      wait_grant(id, t);
      n_total++; if (id != order[g]) $display("FAIL fair_order%0d: got %0d expected %0d", g, id, order[g]); else n_pass++;
      accept(id, (id >= 0) ? prod(id) : 32'h0);
      if (g == 0) set_req(3, 16'h0300, 16'h0005);
      wait_rsp(lat);
      pop_exp;
      n_total++; if (rsp_p !== e.p || int'(rsp_id) != e.id)
        $display("FAIL fair_rsp%0d: got id=%0d p=%h expected id=%0d p=%h", g, rsp_id, rsp_p, e.id, e.p);
      else n_pass++;
      step;
    end
    req_valid = '0;
    step;
  endtask

  initial begin
    test_reset;
    test_single;
    test_extremes;
    test_contention;
    test_backpressure;
    test_reset_mid_wait;
    test_fairness;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
